// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point radix-2 DIT FFT core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the sequencer FSM state encoding, the transform geometry and the
// Q2.14 twiddle magnitudes used by the LUT and butterfly array.
package fft16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_UNLOAD = 2'd3
    } fft_state_t;

    localparam int N_PTS = 16;
    localparam int LOG2N = 4;

    // Q2.14 fixed point: 1.0 and the three distinct twiddle magnitudes
    // cos(pi/8), cos(pi/4), cos(3pi/8) from which every W16^k is built.
    localparam logic signed [15:0] Q14_ONE = 16'sd16384;
    localparam logic signed [15:0] Q14_C1  = 16'sd15137;
    localparam logic signed [15:0] Q14_C2  = 16'sd11585;
    localparam logic signed [15:0] Q14_C3  = 16'sd6270;

endpackage

// File: rtl/fft16_seq_ctrl.sv
// Sequencer for the 16-point FFT: load 16 samples, run 4 butterfly stages, unload 16 results.
// Latency: start->LOAD 1 cycle; RUN is 4*(BFLY_LAT+1) cycles; 1+16+RUN+16 cycles start->done at full rate.
// Backpressure: in_ready only in LOAD; out_ready=0 holds rd_addr indefinitely in UNLOAD.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start/busy/done   transform launch (sampled in IDLE only), activity flag, completion pulse
//   in_valid/in_ready input handshake; ld_we/ld_addr drive the sample RF load port
//   stage/stage_en    LUT stage index and butterfly issue strobe
//   wb_we             butterfly result write-back into the sample RF at LUT addresses
//   out_valid/out_ready/rd_addr/out_last   result stream in natural order
module fft16_seq_ctrl
    import fft16_pkg::*;
#(
    parameter int BFLY_LAT = 2,
    parameter int N_PTS    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic [1:0]       stage,
    output logic             stage_en,
    output logic             wb_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] rd_addr,
    output logic             out_last
);

    localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N_PTS - 1);
    localparam logic [2:0]       LAT_WB     = 3'(BFLY_LAT);
    localparam logic [1:0]       LAST_STAGE = 2'(LOG2N - 1);

    fft_state_t       state_q, state_d;
    logic [2:0]       lat_q, lat_d;
    logic [1:0]       stage_d;
    logic [LOG2N-1:0] ld_addr_d, rd_addr_d;
    logic             done_d;
    logic             busy_d, in_ready_d, out_valid_d, stage_en_d, wb_we_d;
    logic             xfer;

    // The only two combinational outputs: handshake qualifiers.
    assign ld_we    = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign out_last = out_valid & (rd_addr == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        stage_d   = stage;
        ld_addr_d = ld_addr;
        rd_addr_d = rd_addr;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_we) begin
                    ld_addr_d = ld_addr + 1'b1;
                    if (ld_addr == LAST_IDX) begin
                        state_d   = ST_RUN;
                        ld_addr_d = '0;
                        lat_d     = '0;
                        stage_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                // lat_q counts 0 (issue) .. BFLY_LAT (write-back) within a stage.
                if (lat_q == LAT_WB) begin
                    lat_d = '0;
                    if (stage == LAST_STAGE) begin
                        state_d = ST_UNLOAD;
                        stage_d = '0;
                    end else begin
                        stage_d = stage + 2'd1;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_UNLOAD: begin
                if (xfer) begin
                    rd_addr_d = rd_addr + 1'b1;
                    if (rd_addr == LAST_IDX) begin
                        state_d   = ST_IDLE;
                        rd_addr_d = '0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are decoded from next-state so they leave the flops aligned
        // with the state they belong to.
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_UNLOAD);
        stage_en_d  = (state_d == ST_RUN) && (lat_d == 3'd0);
        wb_we_d     = (state_d == ST_RUN) && (lat_d == LAT_WB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            stage     <= '0;
            ld_addr   <= '0;
            rd_addr   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            stage_en  <= 1'b0;
            wb_we     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            stage     <= stage_d;
            ld_addr   <= ld_addr_d;
            rd_addr   <= rd_addr_d;
            done      <= done_d;
            busy      <= busy_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            stage_en  <= stage_en_d;
            wb_we     <= wb_we_d;
        end
    end

endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// Bench for fft16_seq_ctrl: three instances (BFLY_LAT 2, 1, 7) driven with random samples and handshakes.
// Latency: expected event timing is derived from the transform rules with plain arithmetic.
// Backpressure: exercises input gaps, output stalls and random valid/ready.
//
// A behavioural sample RF is written on ld_we and transformed one radix-2 stage per wb_we
// using the stage number the controller presents; unloaded values are compared to a direct DFT.
module tb_fft16_seq_ctrl;

    localparam real PI = 3.14159265358979323846;
    localparam int M_GAP = 1, M_STALL = 2, M_PULSE = 4, M_HOLD = 8, M_RAND = 16, M_ABORT = 32, M_IMPULSE = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start, in_valid, out_ready;
    logic [2:0] busy, done, in_ready, ld_we, stage_en, wb_we, out_valid, out_last;
    logic [3:0] ld_addr [3];
    logic [3:0] rd_addr [3];
    logic [1:0] stage   [3];

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fft16_seq_ctrl #(.BFLY_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 7)), .N_PTS(16)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .ld_we    (ld_we[g]),
            .ld_addr  (ld_addr[g]),
            .stage    (stage[g]),
            .stage_en (stage_en[g]),
            .wb_we    (wb_we[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .rd_addr  (rd_addr[g]),
            .out_last (out_last[g])
        );
    end

    int  n_checks = 0;
    int  n_errs   = 0;
    real x_re [16], x_im [16];
    real rf_re[16], rf_im[16];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int bitrev4(input int i);
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
    endfunction

    // One in-place DIT stage on the bench RF; stage 0 first applies the bit-reversal.
    function automatic void apply_stage(input int s);
        real tr[16], ti[16];
        real th, c, sn, pr, pq;
        int  half;
        if (s == 0) begin
            for (int i = 0; i < 16; i++) begin tr[i] = rf_re[i]; ti[i] = rf_im[i]; end
            for (int i = 0; i < 16; i++) begin rf_re[i] = tr[bitrev4(i)]; rf_im[i] = ti[bitrev4(i)]; end
        end
        half = 1 << s;
        for (int k = 0; k < 16; k += 2 * half) begin
            for (int j = 0; j < half; j++) begin
                th = PI * j / half;
                c  = $cos(th);
                sn = $sin(th);
                pr = rf_re[k+j+half] * c + rf_im[k+j+half] * sn;
                pq = rf_im[k+j+half] * c - rf_re[k+j+half] * sn;
                rf_re[k+j+half] = rf_re[k+j] - pr;
                rf_im[k+j+half] = rf_im[k+j] - pq;
                rf_re[k+j]      = rf_re[k+j] + pr;
                rf_im[k+j]      = rf_im[k+j] + pq;
            end
        end
    endfunction

    function automatic void dft(input int k, output int re, output int im);
        real sr, si, th;
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < 16; n++) begin
            th = 2.0 * PI * (k * n) / 16.0;
            sr += x_re[n] * $cos(th) + x_im[n] * $sin(th);
            si += x_im[n] * $cos(th) - x_re[n] * $sin(th);
        end
        re = rnd(sr);
        im = rnd(si);
    endfunction

    task automatic xform(input int g, input int mode);
        int         lat, cyc, nacc, ntx, last_acc, first_run, first_ov, done_cyc, stall_cnt, abort_phase;
        int         e_re, e_im, per;
        bit         last_seen, prev_stalled, finished;
        logic [3:0] prev_rd;
        int         run_stage[$];
        int         run_se[$];
        int         run_wb[$];

        lat = lat_of(g);
        per = lat + 1;
        for (int i = 0; i < 16; i++) begin
            if ((mode & M_IMPULSE) != 0) begin
                x_re[i] = (i == 0) ? 16384.0 : 0.0;
                x_im[i] = 0.0;
            end else begin
                x_re[i] = real'(int'($urandom_range(2000)) - 1000);
                x_im[i] = real'(int'($urandom_range(2000)) - 1000);
            end
            rf_re[i] = 0.0;
            rf_im[i] = 0.0;
        end

        @(negedge clk);
        start[g] = 1'b1; in_valid[g] = 1'b0; out_ready[g] = 1'b1;
        #1;
        chk("idle_before_start", busy[g], 0);

        cyc = 0; nacc = 0; ntx = 0; last_acc = -1; first_run = -1; first_ov = -1; done_cyc = -1;
        stall_cnt = 0; abort_phase = 0; last_seen = 0; prev_stalled = 0; finished = 0; prev_rd = '0;

        while (!finished && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if ((mode & M_HOLD) != 0)                      start[g] = 1'b1;
            else if ((mode & M_PULSE) != 0 && !last_seen) start[g] = 1'($urandom_range(1));
            else                                           start[g] = 1'b0;
            if ((mode & M_GAP) != 0)       in_valid[g] = 1'((cyc % 2) == 1);
            else if ((mode & M_RAND) != 0) in_valid[g] = 1'($urandom_range(1));
            else                           in_valid[g] = 1'b1;
            if ((mode & M_STALL) != 0 && ntx == 5 && stall_cnt < 5) begin
                out_ready[g] = 1'b0;
                stall_cnt++;
            end else if ((mode & M_RAND) != 0) begin
                out_ready[g] = 1'($urandom_range(1));
            end else begin
                out_ready[g] = 1'b1;
            end
            rst = (abort_phase == 1);
            #1;

            if (abort_phase == 2) begin
                chk("rst_busy",     busy[g],      0);
                chk("rst_done",     done[g],      0);
                chk("rst_in_ready", in_ready[g],  0);
                chk("rst_ld_we",    ld_we[g],     0);
                chk("rst_ld_addr",  ld_addr[g],   0);
                chk("rst_stage",    stage[g],     0);
                chk("rst_stage_en", stage_en[g],  0);
                chk("rst_wb_we",    wb_we[g],     0);
                chk("rst_out_valid",out_valid[g], 0);
                chk("rst_rd_addr",  rd_addr[g],   0);
                chk("rst_out_last", out_last[g],  0);
                finished = 1;
            end else begin
                if (ld_we[g]) begin
                    chk("ld_addr", ld_addr[g], nacc);
                    rf_re[ld_addr[g]] = x_re[nacc & 15];
                    rf_im[ld_addr[g]] = x_im[nacc & 15];
                    nacc++;
                    last_acc = cyc;
                end
                if (busy[g] && !in_ready[g] && !out_valid[g]) begin
                    if (first_run < 0) first_run = cyc;
                    run_stage.push_back(int'(stage[g]));
                    run_se.push_back(int'(stage_en[g]));
                    run_wb.push_back(int'(wb_we[g]));
                    if ((mode & M_ABORT) != 0 && stage_en[g] && stage[g] == 2'd2 && abort_phase == 0)
                        abort_phase = 1;
                end
                if (wb_we[g]) apply_stage(int'(stage[g]));
                if (out_valid[g]) begin
                    if (first_ov < 0) first_ov = cyc;
                    if (prev_stalled) chk("rd_addr_hold", rd_addr[g], prev_rd);
                    if (out_ready[g]) begin
                        chk("rd_addr", rd_addr[g], ntx);
                        chk("out_last", out_last[g], (ntx == 15) ? 1 : 0);
                        if ((mode & M_IMPULSE) != 0) begin
                            e_re = 16384;
                            e_im = 0;
                        end else begin
                            dft(ntx, e_re, e_im);
                        end
                        chk("data_re", rnd(rf_re[rd_addr[g]]), e_re);
                        chk("data_im", rnd(rf_im[rd_addr[g]]), e_im);
                        ntx++;
                        if (ntx == 16) last_seen = 1;
                    end
                    prev_stalled = !out_ready[g];
                    prev_rd      = rd_addr[g];
                end else begin
                    prev_stalled = 0;
                end
                if (done[g]) begin
                    done_cyc = cyc;
                    chk("done_busy", busy[g], 0);
                    finished = 1;
                end
                if (rst) abort_phase = 2;
            end
        end
        rst = 1'b0;
        if (!finished) chk("timeout", cyc, -1);

        if ((mode & M_ABORT) != 0) begin
            start[g] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                #1;
                chk("abort_no_done", done[g], 0);
            end
            return;
        end

        chk("accept_count", nacc, 16);
        chk("xfer_count", ntx, 16);
        chk("run_start", first_run, last_acc + 1);
        chk("run_len", run_stage.size(), 4 * per);
        for (int k = 0; k < run_stage.size() && k < 4 * per; k++) begin
            chk("run_stage",    run_stage[k], k / per);
            chk("run_stage_en", run_se[k],    ((k % per) == 0) ? 1 : 0);
            chk("run_wb_we",    run_wb[k],    ((k % per) == lat) ? 1 : 0);
        end
        chk("first_out_valid", first_ov, first_run + 4 * per);
        if ((mode & (M_GAP | M_STALL | M_RAND)) == 0)
            chk("start_to_done", done_cyc, 1 + 16 + 4 * per + 16);

        if ((mode & M_HOLD) != 0) begin
            @(negedge clk);
            start[g] = 1'b1;
            #1;
            chk("relaunch_in_ready", in_ready[g], 1);
            chk("relaunch_busy", busy[g], 1);
            @(negedge clk);
            start[g] = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("relaunch_reset_busy", busy[g], 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = '0;
        in_valid = 3'b111;
        out_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("reset_busy",      busy[g],      0);
            chk("reset_done",      done[g],      0);
            chk("reset_in_ready",  in_ready[g],  0);
            chk("reset_ld_we",     ld_we[g],     0);
            chk("reset_ld_addr",   ld_addr[g],   0);
            chk("reset_stage",     stage[g],     0);
            chk("reset_stage_en",  stage_en[g],  0);
            chk("reset_wb_we",     wb_we[g],     0);
            chk("reset_out_valid", out_valid[g], 0);
            chk("reset_rd_addr",   rd_addr[g],   0);
            chk("reset_out_last",  out_last[g],  0);
        end
        rst = 1'b0;
        in_valid = '0;

        xform(0, M_IMPULSE);
        xform(0, 0);
        xform(0, M_GAP | M_STALL);
        xform(0, M_PULSE);
        xform(0, M_RAND);
        xform(0, M_ABORT);
        xform(0, 0);
        xform(0, M_HOLD);
        xform(1, 0);
        xform(2, 0);
        xform(1, M_RAND | M_PULSE);
        xform(2, M_GAP | M_STALL);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
